// File: rtl/ne_hd_frame_packer_pkg.sv
// Shared NE decoder constants: hard-decision word geometry derived from the
// lifting size and the number of information block columns, plus the
// output-stage state encoding used by the frame packer.
package ne_hd_frame_packer_pkg;

  localparam int NE_Z       = 511;
  localparam int NE_KB      = 14;
  localparam int NE_HDWIDTH = 32;
  localparam int NE_MSGBITS = NE_KB * NE_Z;

  // Words needed to carry one decoded message, and the valid bits left in
  // the final word (7154 bits -> 224 words, 18 bits in the last one).
  localparam int NE_WORDSPERFRAME = (NE_MSGBITS + NE_HDWIDTH - 1) / NE_HDWIDTH;
  localparam int NE_LASTBITS      = NE_MSGBITS - (NE_WORDSPERFRAME - 1) * NE_HDWIDTH;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_t;

endpackage

// File: rtl/ne_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. Read data is presented straight
// from the memory array; the consumer registers it, so a pop and the capture
// of the popped word happen on the same edge.
module ne_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_write;
  logic             do_read;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level = wr_ptr_reg - rd_ptr_reg;

  // A write while full is legal only when a read frees the slot on the same edge.
  assign do_write = wr_en && (!full || rd_en);
  assign do_read  = rd_en && !empty;

  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  // Storage array; left unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  // Pointer updates; wrap at DEPTH falls out of the binary width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_read)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ne_hd_frame_packer.sv
// Tags decoder hard-decision words with their message position, buffers them
// and re-emits them on a valid/ready stream with end-of-frame and bit-count
// sideband. The input side has no backpressure, so overflows drop words but
// the position counter keeps running to preserve frame alignment.
module ne_hd_frame_packer
  import ne_hd_frame_packer_pkg::*;
#(
  parameter int HDWIDTH       = NE_HDWIDTH,
  parameter int FIFODEPTH     = 32,
  parameter int ADDRESSWIDTH  = 5,
  parameter int WORDSPERFRAME = NE_WORDSPERFRAME,
  parameter int LASTBITS      = NE_LASTBITS,
  parameter int FCNTWIDTH     = 16
) (
  input  logic                    outclk,
  input  logic                    rst,
  input  logic                    datavalid,
  input  logic [HDWIDTH-1:0]      HD_out,
  input  logic                    m_ready,
  output logic                    m_valid,
  output logic [HDWIDTH-1:0]      m_data,
  output logic                    m_last,
  output logic [5:0]              m_nbits,
  output logic [FCNTWIDTH-1:0]    frame_count,
  output logic                    overflow,
  output logic [ADDRESSWIDTH:0]   fifo_level
);

  localparam int CNTW = ($clog2(WORDSPERFRAME) > 0) ? $clog2(WORDSPERFRAME) : 1;
  localparam logic [CNTW-1:0] LAST_IDX    = CNTW'(WORDSPERFRAME - 1);
  localparam logic [5:0]      NBITS_FULL  = 6'(HDWIDTH);
  localparam logic [5:0]      NBITS_LAST  = 6'(LASTBITS);

  logic [CNTW-1:0]      in_cnt_reg;
  logic                 last_tag;
  logic                 fifo_wr_en;
  logic                 fifo_rd_en;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [HDWIDTH:0]     fifo_wdata;
  logic [HDWIDTH:0]     fifo_rdata;
  out_state_t           state_reg;
  out_state_t           state_next;
  logic                 load;
  logic                 handshake;
  logic                 drop;
  logic [HDWIDTH-1:0]   data_reg;
  logic                 last_reg;
  logic [5:0]           nbits_reg;
  logic [FCNTWIDTH-1:0] frame_cnt_reg;
  logic                 overflow_reg;

  assign last_tag   = (in_cnt_reg == LAST_IDX);
  assign fifo_wdata = {last_tag, HD_out};

  assign m_valid   = (state_reg == OUT_HOLD);
  assign handshake = m_valid && m_ready;

  // The output stage only pulls from the FIFO when it is empty or being drained.
  assign fifo_rd_en = load;
  assign fifo_wr_en = datavalid && (!fifo_full || load);
  assign drop       = datavalid && fifo_full && !load;

  ne_sync_fifo #(
    .WIDTH (HDWIDTH + 1),
    .DEPTH (FIFODEPTH),
    .AW    (ADDRESSWIDTH)
  ) u_fifo (
    .clk     (outclk),
    .rst_n   (rst),
    .wr_en   (fifo_wr_en),
    .wr_data (fifo_wdata),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Message position counter; advances on every input word, kept or dropped.
  always_ff @(posedge outclk or negedge rst) begin
    if (!rst) begin
      in_cnt_reg <= '0;
    end else if (datavalid) begin
      in_cnt_reg <= last_tag ? '0 : in_cnt_reg + 1'b1;
    end
  end

  // Output-stage next state and FIFO load decision.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      OUT_EMPTY: begin
        if (!fifo_empty) begin
          load       = 1'b1;
          state_next = OUT_HOLD;
        end
      end
      OUT_HOLD: begin
        if (m_ready) begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_next = OUT_EMPTY;
          end
        end
      end
      default: state_next = OUT_EMPTY;
    endcase
  end

  // Output-stage state register.
  always_ff @(posedge outclk or negedge rst) begin
    if (!rst) begin
      state_reg <= OUT_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Output word registers; only change on a load so they hold during stalls.
  always_ff @(posedge outclk or negedge rst) begin
    if (!rst) begin
      data_reg  <= '0;
      last_reg  <= 1'b0;
      nbits_reg <= NBITS_FULL;
    end else if (load) begin
      data_reg  <= fifo_rdata[HDWIDTH-1:0];
      last_reg  <= fifo_rdata[HDWIDTH];
      nbits_reg <= fifo_rdata[HDWIDTH] ? NBITS_LAST : NBITS_FULL;
    end
  end

  // Completed-frame counter, bumped when the tagged last word is accepted.
  always_ff @(posedge outclk or negedge rst) begin
    if (!rst) begin
      frame_cnt_reg <= '0;
    end else if (handshake && last_reg) begin
      frame_cnt_reg <= frame_cnt_reg + 1'b1;
    end
  end

  // Sticky drop indicator.
  always_ff @(posedge outclk or negedge rst) begin
    if (!rst) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end
  end

  assign m_data      = data_reg;
  assign m_last      = last_reg;
  assign m_nbits     = nbits_reg;
  assign frame_count = frame_cnt_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_ne_hd_frame_packer.sv
// Directed bench for the hard-decision frame packer. A second instance with a
// 2-bit frame counter shares all inputs and is used for the wrap check.
module tb_ne_hd_frame_packer;

  logic        clk;
  logic        rst;
  logic        datavalid;
  logic [31:0] HD_out;
  logic        m_ready;

  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic [5:0]  m_nbits;
  logic [15:0] frame_count;
  logic        overflow;
  logic [5:0]  fifo_level;

  logic        m_valid2;
  logic [31:0] m_data2;
  logic        m_last2;
  logic [5:0]  m_nbits2;
  logic [1:0]  frame_count2;
  logic        overflow2;
  logic [5:0]  fifo_level2;

  int checks;
  int errors;

  ne_hd_frame_packer dut (
    .outclk      (clk),
    .rst         (rst),
    .datavalid   (datavalid),
    .HD_out      (HD_out),
    .m_ready     (m_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_nbits     (m_nbits),
    .frame_count (frame_count),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  ne_hd_frame_packer #(.FCNTWIDTH(2)) dut2 (
    .outclk      (clk),
    .rst         (rst),
    .datavalid   (datavalid),
    .HD_out      (HD_out),
    .m_ready     (m_ready),
    .m_valid     (m_valid2),
    .m_data      (m_data2),
    .m_last      (m_last2),
    .m_nbits     (m_nbits2),
    .frame_count (frame_count2),
    .overflow    (overflow2),
    .fifo_level  (fifo_level2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    datavalid = 1'b0;
    m_ready = 1'b0;
    HD_out = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    datavalid = 1'b0;
    m_ready = 1'b0;
    HD_out = '0;
    tick();
    checks++;
    if (m_valid !== 1'b0 || m_data !== 32'd0 || m_last !== 1'b0 || m_nbits !== 6'd32 ||
        frame_count !== 16'd0 || overflow !== 1'b0 || fifo_level !== 6'd0) begin
      errors++;
      $display("FAIL reset_values: valid %b data %0d last %b nbits %0d fc %0d ovf %b lvl %0d, expected 0 0 0 32 0 0 0",
               m_valid, m_data, m_last, m_nbits, frame_count, overflow, fifo_level);
    end
    rst = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single_frame();
    int e;
    e = 0;
    do_reset();
    m_ready = 1'b1;
    for (int c = 0; c < 240; c++) begin
      if (c == 1) begin
        checks++;
        if (m_valid !== 1'b0) begin
          errors++;
          $display("FAIL latency_early: m_valid %b one edge after push, expected 0", m_valid);
        end
      end
      if (c == 2) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'd0) begin
          errors++;
          $display("FAIL latency: valid %b data %0d two edges after push, expected 1 0", m_valid, m_data);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 32'(e) || m_last !== (e == 223) || m_nbits !== ((e == 223) ? 6'd18 : 6'd32)) begin
          errors++;
          $display("FAIL single_frame word: data %0d last %b nbits %0d, expected data %0d last %b nbits %0d",
                   m_data, m_last, m_nbits, e, (e == 223), (e == 223) ? 18 : 32);
        end
        e++;
      end
      datavalid = (c < 224);
      HD_out = 32'(c);
      tick();
    end
    checks++;
    if (e != 224 || frame_count !== 16'd1 || fifo_level !== 6'd0) begin
      errors++;
      $display("FAIL single_frame end: words %0d fc %0d lvl %0d, expected 224 1 0", e, frame_count, fifo_level);
    end
    $display("test_single_frame done, %0d words", e);
  endtask

  task automatic test_overflow();
    int e;
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 33; i++) begin
      datavalid = 1'b1;
      HD_out = 32'(i);
      tick();
    end
    checks++;
    if (fifo_level !== 6'd32 || overflow !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'd0) begin
      errors++;
      $display("FAIL overflow_fill: lvl %0d ovf %b valid %b data %0d, expected 32 0 1 0",
               fifo_level, overflow, m_valid, m_data);
    end
    HD_out = 32'd33;
    tick();
    datavalid = 1'b0;
    checks++;
    if (fifo_level !== 6'd32 || overflow !== 1'b1 || m_data !== 32'd0) begin
      errors++;
      $display("FAIL overflow_drop: lvl %0d ovf %b data %0d, expected 32 1 0", fifo_level, overflow, m_data);
    end
    m_ready = 1'b1;
    e = 0;
    for (int c = 0; c < 40; c++) begin
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 32'(e) || m_last !== 1'b0) begin
          errors++;
          $display("FAIL overflow_drain: data %0d last %b, expected %0d 0", m_data, m_last, e);
        end
        e++;
      end
      tick();
    end
    checks++;
    if (e != 33) begin
      errors++;
      $display("FAIL overflow_drain_count: got %0d words, expected 33", e);
    end
    // Word 33 was dropped; the rest of the frame resumes at 34.
    e = 34;
    for (int c = 0; c < 200; c++) begin
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 32'(e) || m_last !== (e == 223)) begin
          errors++;
          $display("FAIL overflow_tail: data %0d last %b, expected %0d %b", m_data, m_last, e, (e == 223));
        end
        e++;
      end
      datavalid = (c < 190);
      HD_out = 32'(34 + c);
      tick();
    end
    checks++;
    if (e != 224 || frame_count !== 16'd1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_end: next %0d fc %0d ovf %b, expected 224 1 1", e, frame_count, overflow);
    end
    $display("test_overflow done");
  endtask

  task automatic test_reset_mid_frame();
    int e;
    m_ready = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      datavalid = 1'b1;
      HD_out = 32'(1000 + i);
      tick();
    end
    rst = 1'b0;
    #2;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 32'd0 || m_last !== 1'b0 || m_nbits !== 6'd32 ||
        frame_count !== 16'd0 || overflow !== 1'b0 || fifo_level !== 6'd0) begin
      errors++;
      $display("FAIL async_reset: valid %b data %0d last %b nbits %0d fc %0d ovf %b lvl %0d, expected 0 0 0 32 0 0 0",
               m_valid, m_data, m_last, m_nbits, frame_count, overflow, fifo_level);
    end
    datavalid = 1'b0;
    tick();
    rst = 1'b1;
    e = 0;
    for (int c = 0; c < 240; c++) begin
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 32'(e) || m_last !== (e == 223)) begin
          errors++;
          $display("FAIL post_reset_frame: data %0d last %b, expected %0d %b", m_data, m_last, e, (e == 223));
        end
        e++;
      end
      datavalid = (c < 224);
      HD_out = 32'(c);
      tick();
    end
    checks++;
    if (e != 224 || frame_count !== 16'd1) begin
      errors++;
      $display("FAIL post_reset_end: words %0d fc %0d, expected 224 1", e, frame_count);
    end
    $display("test_reset_mid_frame done");
  endtask

  task automatic test_full_with_pop();
    int e;
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 33; i++) begin
      datavalid = 1'b1;
      HD_out = 32'(i);
      tick();
    end
    HD_out = 32'd33;
    m_ready = 1'b1;
    tick();
    datavalid = 1'b0;
    checks++;
    if (overflow !== 1'b0 || fifo_level !== 6'd32 || m_valid !== 1'b1 || m_data !== 32'd1) begin
      errors++;
      $display("FAIL full_push_pop: ovf %b lvl %0d valid %b data %0d, expected 0 32 1 1",
               overflow, fifo_level, m_valid, m_data);
    end
    e = 1;
    for (int c = 0; c < 40; c++) begin
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 32'(e)) begin
          errors++;
          $display("FAIL full_drain: data %0d, expected %0d", m_data, e);
        end
        e++;
      end
      tick();
    end
    checks++;
    if (e != 34 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_drain_end: next %0d ovf %b, expected 34 0", e, overflow);
    end
    $display("test_full_with_pop done");
  endtask

  task automatic test_ready_toggle();
    int e;
    int g;
    int stalls;
    logic        held;
    logic [31:0] held_data;
    logic        held_last;
    do_reset();
    e = 0;
    g = 0;
    stalls = 0;
    held = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      m_ready = c[0];
      datavalid = (c[0] == 1'b0) && (g < 672);
      HD_out = 32'(g);
      if (held) begin
        checks++;
        stalls++;
        if (m_valid !== 1'b1 || m_data !== held_data || m_last !== held_last) begin
          errors++;
          $display("FAIL stall_hold: valid %b data %0d last %b, expected 1 %0d %b",
                   m_valid, m_data, m_last, held_data, held_last);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 32'(e) || m_last !== ((e % 224) == 223)) begin
          errors++;
          $display("FAIL toggle_word: data %0d last %b, expected %0d %b", m_data, m_last, e, ((e % 224) == 223));
        end
        e++;
      end
      held = m_valid && !m_ready;
      held_data = m_data;
      held_last = m_last;
      if (datavalid) g++;
      tick();
      if (e == 672 && g == 672) break;
    end
    checks++;
    if (e != 672 || frame_count !== 16'd3 || overflow !== 1'b0 || stalls == 0) begin
      errors++;
      $display("FAIL toggle_end: words %0d fc %0d ovf %b stalls %0d, expected 672 3 0 >0",
               e, frame_count, overflow, stalls);
    end
    $display("test_ready_toggle done, %0d stalls", stalls);
  endtask

  task automatic test_fcnt_wrap();
    logic [1:0] fexp [5];
    int nf;
    logic hs_last;
    fexp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    nf = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 1130; c++) begin
      datavalid = (c < 1120);
      HD_out = 32'(c);
      hs_last = m_valid2 && m_last2;
      tick();
      if (hs_last && nf < 5) begin
        checks++;
        if (frame_count2 !== fexp[nf]) begin
          errors++;
          $display("FAIL fcnt_wrap frame %0d: count %0d, expected %0d", nf + 1, frame_count2, fexp[nf]);
        end
        nf++;
      end
    end
    checks++;
    if (nf != 5 || frame_count !== 16'd5) begin
      errors++;
      $display("FAIL fcnt_wrap_end: frames %0d wide count %0d, expected 5 5", nf, frame_count);
    end
    $display("test_fcnt_wrap done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    datavalid = 1'b0;
    m_ready = 1'b0;
    HD_out = '0;
    test_reset();
    test_single_frame();
    test_overflow();
    test_reset_mid_frame();
    test_full_with_pop();
    test_ready_toggle();
    test_fcnt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
